logic_gate_pipe: RTL
====================

// Module: logic_gate_pipe
// PURPOSE
//  Parametrised, registered successor to the 2-input OR gate. Reduces NUM_IN operands of WIDTH
//  bits bitwise with a runtime-selected op (AND/OR/XOR/NAND/NOR/XNOR/PASS), behind valid/ready.
//  Optional accumulate mode folds a multi-beat burst into a single result plus beat count.
//  Sits between stream producers and consumers in the gate-level datapath library.
// PARAMETERS
//  WIDTH   8  bits per operand and per result
//  NUM_IN  2  operands per beat, legal range 2..8
//  CNT_W   4  width of the beat counter; saturates at 2^CNT_W-1
// PORTS
//  clk        in   1             rising-edge clock
//  rst_n      in   1             asynchronous, active-low reset
//  in_valid   in   1             input beat valid
//  in_ready   out  1             block accepts the beat this cycle
//  in_data    in   NUM_IN*WIDTH  operand k = in_data[k*WIDTH +: WIDTH]
//  op         in   3             0 AND,1 OR,2 XOR,3 NAND,4 NOR,5 XNOR,6 PASS(operand 0),7 illegal
//  acc_mode   in   1             1: accumulate burst until acc_last
//  acc_last   in   1             final beat of burst (only meaningful with acc_mode)
//  out_valid  out  1             result valid
//  out_ready  in   1             downstream accepts result
//  out_data   out  WIDTH         result
//  out_beats  out  CNT_W         beats folded into this result (1 in single mode)
//  op_err     out  1             sticky: an op=7 beat was accepted
// BEHAVIOUR
//  - Reset (async assert, sync release): out_valid=0, out_data=0, out_beats=0, op_err=0, state IDLE.
//  - Accept = in_valid & in_ready. in_ready = !out_valid | out_ready (combinational, all states).
//  - Beat reduce: base op (AND/OR/XOR) across all NUM_IN operands; NAND/NOR/XNOR = inverted base.
//    PASS = operand 0. op=7 -> result 0, op_err set, beat otherwise treated as single-mode.
//  - Single mode (acc_mode=0 on accepted beat in IDLE): result registered; out_valid high the
//    cycle after accept (latency 1), out_beats=1. Back-to-back full throughput while out_ready=1.
//  - Output holds out_data/out_beats stable while out_valid & !out_ready.
//  - FSM IDLE/ACCUM:
//    IDLE, accept, acc_mode=1, acc_last=0 -> ACCUM; latch op (op_q), acc = non-inverted beat
//      result, cnt=1. No output.
//    IDLE, accept, acc_mode=1, acc_last=1 -> IDLE; emits as single beat, out_beats=1.
//    ACCUM, accept, acc_last=0 -> ACCUM; acc = acc <base op_q> beat_base; cnt+=1 (saturating).
//    ACCUM, accept, acc_last=1 -> IDLE; emit final (inversion applied once at emit for
//      NAND/NOR/XNOR); out_beats=cnt+1 saturating. PASS accumulates as last operand-0 value.
//  - In ACCUM, op and acc_mode on later beats are ignored (op_q governs); op=7 on first beat
//    never enters ACCUM.
//  - Non-accepted cycles change no state. Reset mid-burst discards acc and cnt; nothing emitted.
//  - Counter saturation: out_beats sticks at 2^CNT_W-1; accumulation continues correctly.
// STRUCTURE
//  - Shared package gate_pkg: op encoding localparams (OP_AND..OP_PASS, OP_ILLEGAL), state enum.
//  - One sub-module: logic_reduce (combinational NUM_IN x WIDTH base reduction, op -> base/invert).
//  - Top: FSM, accumulator, beat counter, output register, handshake.
// TESTING
//  - Reset: rst_n=0 mid-stream -> all outputs 0 immediately, in_ready=1 after release.
//  - Single OR, NUM_IN=2: A=0x0F,B=0xF0, op=1 -> next cycle out_data=0xFF, out_beats=1.
//  - Truth-table sweep W=1: A,B in {00,01,10,11} all ops -> AND 0001, OR 0111, XOR 0110 etc.
//  - Backpressure: out_ready=0 two cycles -> out_data stable, in_ready=0, no beat lost.
//  - Accum XNOR 3 beats (0x01,0x00),(0x02,0x00),(0x04,0x00) -> one output 0xF8, out_beats=3.
//  - op=7 accepted -> out_data=0, op_err=1 held until reset; CNT_W=2, 5-beat OR burst -> beats=3.

Source files
------------

// File: rtl/gate_pkg.sv
// Shared definitions for the gate-level datapath library: op encodings, FSM states and
// helpers that split an op into its base reduction and output inversion.
package gate_pkg;

  localparam logic [2:0] OP_AND     = 3'd0;
  localparam logic [2:0] OP_OR      = 3'd1;
  localparam logic [2:0] OP_XOR     = 3'd2;
  localparam logic [2:0] OP_NAND    = 3'd3;
  localparam logic [2:0] OP_NOR     = 3'd4;
  localparam logic [2:0] OP_XNOR    = 3'd5;
  localparam logic [2:0] OP_PASS    = 3'd6;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  typedef enum logic {StIdle, StAccum} state_e;

  typedef enum logic [1:0] {BaseAnd, BaseOr, BaseXor, BasePass} base_e;

  function automatic base_e op_base(input logic [2:0] op);
    case (op)
      OP_AND, OP_NAND: op_base = BaseAnd;
      OP_OR, OP_NOR:   op_base = BaseOr;
      OP_XOR, OP_XNOR: op_base = BaseXor;
      default:         op_base = BasePass;
    endcase
  endfunction

  function automatic logic op_invert(input logic [2:0] op);
    return (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR);
  endfunction

endpackage

// File: rtl/logic_gate_pipe_if.sv
// Stream interface of logic_gate_pipe: operand beats in, folded results out.
interface logic_gate_pipe_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_IN = 2,
  parameter int unsigned CNT_W  = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [2:0]              op;
  logic                    acc_mode;
  logic                    acc_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
  logic [CNT_W-1:0]        out_beats;
  logic                    op_err;

  modport master (
    output in_valid, in_data, op, acc_mode, acc_last, out_ready,
    input  in_ready, out_valid, out_data, out_beats, op_err
  );

  modport slave (
    input  in_valid, in_data, op, acc_mode, acc_last, out_ready,
    output in_ready, out_valid, out_data, out_beats, op_err
  );
endinterface

// File: rtl/logic_reduce.sv
// Combinational bitwise reduction of NUM_IN operands; reports the base (non-inverted) result
// together with whether the op wants inversion and whether it is the illegal encoding.
module logic_reduce
  import gate_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_IN = 2
) (
  input  logic [NUM_IN*WIDTH-1:0] data,
  input  logic [2:0]              op,
  output logic [WIDTH-1:0]        result,
  output logic                    invert,
  output logic                    illegal
);

  logic [WIDTH-1:0] and_r;
  logic [WIDTH-1:0] or_r;
  logic [WIDTH-1:0] xor_r;

  always_comb begin
    and_r = data[0 +: WIDTH];
    or_r  = data[0 +: WIDTH];
    xor_r = data[0 +: WIDTH];
    for (int unsigned k = 1; k < NUM_IN; k++) begin
      and_r = and_r & data[k*WIDTH +: WIDTH];
      or_r  = or_r  | data[k*WIDTH +: WIDTH];
      xor_r = xor_r ^ data[k*WIDTH +: WIDTH];
    end
    case (op_base(op))
      BaseAnd: result = and_r;
      BaseOr:  result = or_r;
      BaseXor: result = xor_r;
      default: result = data[0 +: WIDTH];
    endcase
  end

  assign invert  = op_invert(op);
  assign illegal = (op == OP_ILLEGAL);

endmodule

// File: rtl/logic_gate_pipe.sv
// Registered NUM_IN-operand bitwise gate with valid/ready handshake and an optional
// accumulate mode that folds a burst into one result plus a saturating beat count.
module logic_gate_pipe
  import gate_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_IN = 2,
  parameter int unsigned CNT_W  = 4
) (
  input logic              clk,
  input logic              rst_n,
  logic_gate_pipe_if.slave bus
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0] out_beats_q, out_beats_d;
  logic             op_err_q, op_err_d;

  logic             in_ready;
  logic             accept;
  logic [2:0]       cur_op;
  logic [WIDTH-1:0] beat_base;
  logic             beat_inv;
  logic             beat_illegal;
  logic [WIDTH-1:0] folded;
  logic [CNT_W-1:0] cnt_inc;

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;
  // Once a burst is open the latched op governs; the live op input is ignored.
  assign cur_op   = (state_q == StAccum) ? op_q : bus.op;
  assign cnt_inc  = (cnt_q == CntMax) ? CntMax : cnt_q + CntOne;

  logic_reduce #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_reduce (
    .data    (bus.in_data),
    .op      (cur_op),
    .result  (beat_base),
    .invert  (beat_inv),
    .illegal (beat_illegal)
  );

  always_comb begin
    case (op_base(op_q))
      BaseAnd: folded = acc_q & beat_base;
      BaseOr:  folded = acc_q | beat_base;
      BaseXor: folded = acc_q ^ beat_base;
      default: folded = beat_base;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    out_data_d  = out_data_q;
    out_beats_d = out_beats_q;
    op_err_d    = op_err_q;
    if (accept) begin
      unique case (state_q)
        StIdle: begin
          if (beat_illegal) begin
            out_valid_d = 1'b1;
            out_data_d  = '0;
            out_beats_d = CntOne;
            op_err_d    = 1'b1;
          end else if (bus.acc_mode && !bus.acc_last) begin
            state_d = StAccum;
            op_d    = bus.op;
            acc_d   = beat_base;
            cnt_d   = CntOne;
          end else begin
            out_valid_d = 1'b1;
            out_data_d  = beat_inv ? ~beat_base : beat_base;
            out_beats_d = CntOne;
          end
        end
        StAccum: begin
          if (bus.acc_last) begin
            state_d     = StIdle;
            out_valid_d = 1'b1;
            out_data_d  = beat_inv ? ~folded : folded;
            out_beats_d = cnt_inc;
          end else begin
            acc_d = folded;
            cnt_d = cnt_inc;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op_q        <= OP_AND;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_beats_q <= '0;
      op_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_beats_q <= out_beats_d;
      op_err_q    <= op_err_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_beats = out_beats_q;
  assign bus.op_err    = op_err_q;

endmodule
